msk_pattern_checker: RTL and testbench
======================================

Name: msk_pattern_checker

Overview:
- Bit-error checker for the decoded MSK RX stream. It sits after the slicer/decoder (msk_slicer_dec) and replaces the passive shifter viewer in closed-loop benches and on hardware.
- It hunts for a known repeating FDW-bit pattern, locks its phase, and then counts bit errors against it.
- Lock and loss use a three-state machine, so carrier/timing slips are reported, not just displayed.

Parameters:
- FDW, 256, pattern length in bits (≥ SYNC_W, ≥ 2).
- FIXED_DATA, 256'h9010…ffa50ffe, reference pattern; transmitted MSB first.
- SYNC_W, 32, search-window width. The window is FIXED_DATA[FDW-1 -: SYNC_W].
- SYNC_TOL, 0, maximum Hamming distance accepted in SEARCH.
- VERIFY_MAX_ERR, 2, maximum errors in one VERIFY period for promotion to LOCKED.
- UNLOCK_ERR, 16, a LOCKED period with more errors than this is a "bad period".
- LOSS_CNT, 3, number of consecutive bad periods that forces a return to SEARCH.
- CNT_W, 32, width of the bit and error counters.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- data_i, in, 1, decoded bit.
- data_val_i, in, 1, qualifies data_i; no backpressure.
- clear_i, in, 1, zeroes the statistics counters; lock state is unaffected.
- state_o, out, 2, current state: 0 SEARCH, 1 VERIFY, 2 LOCKED.
- locked_o, out, 1, high when state_o == LOCKED.
- sync_o, out, 1, one-cycle pulse at each pattern wrap while LOCKED.
- bit_cnt_o, out, CNT_W, bits checked while LOCKED.
- err_cnt_o, out, CNT_W, errors counted while LOCKED.
- period_err_o, out, $clog2(FDW+1), error count of the last completed period.
- inverted_o, out, 1, polarity flag; constant 0 unless POLARITY_AUTO_EN is defined.

Behaviour:
- Reset values: all outputs 0, state SEARCH, shift register 0, pointer 0, loss counter 0. Reset mid-operation aborts the period immediately.
- Registered outputs: the effect of a bit sampled with data_val_i is visible on the next clk edge. No state changes without data_val_i.
- SEARCH:
  - The SYNC_W shift register takes data_i into the LSB on every valid bit.
  - Compare {shreg[SYNC_W-2:0], data_i} with the sync window.
  - Hamming distance ≤ SYNC_TOL: pointer ← SYNC_W mod FDW, period error count ← distance, state → VERIFY.
- VERIFY:
  - Expected bit is FIXED_DATA[FDW-1-ptr]. A mismatch increments the period error count.
  - The pointer advances and wraps FDW-1 → 0.
  - At wrap: period errors ≤ VERIFY_MAX_ERR → LOCKED, otherwise → SEARCH with the shift register cleared.
  - Early abort: period errors exceeding VERIFY_MAX_ERR mid-period → SEARCH on that bit.
- LOCKED:
  - Compare bits as in VERIFY. bit_cnt_o and err_cnt_o increment and saturate at all-ones.
  - At wrap: sync_o = 1, period_err_o ← errors including the wrap bit, period count resets.
  - Bad period: loss counter +1. Good period: loss counter → 0.
  - Loss counter reaching LOSS_CNT → SEARCH. Counters hold, locked_o drops on the same edge.
- clear_i:
  - Zeroes bit_cnt_o, err_cnt_o and period_err_o.
  - If it coincides with a valid bit, clear wins for the counters; the bit is still processed for state and pointer.
- Simultaneous loss and wrap: state goes to SEARCH and no sync_o pulse is issued.
- Error sum widths: period count $clog2(FDW+1) bits, no overflow possible.

Optional Feature:
- Macro MSK_PATTERN_CHECKER_POLARITY_AUTO_EN.
- Defined:
  - SEARCH also matches against the bitwise-inverted window (180° carrier ambiguity).
  - An inverted match sets inverted_o = 1, and all later comparisons use ~data_i.
  - If both normal and inverted windows match, the normal one wins.
  - inverted_o clears on return to SEARCH.
- Not defined: only the normal-polarity window is matched and inverted_o is tied to 0.

Decomposition:
- Package msk_chk_pkg holds:
  - the state enum (SEARCH, VERIFY, LOCKED, 2 bits);
  - a popcount function;
  - the default pattern constant FIXED_DATA_DEFAULT (256 bits).
- One sub-module, msk_hamming_match (SYNC_W, SYNC_TOL). It is a registered-free popcount comparator and is instantiated twice when the polarity feature is defined.

Test Plan:
1. Reset mid-stream: assert rst for 1 clk while LOCKED → state_o = 0, all counters 0 on the next edge.
2. Clean pattern: feed 3 error-free repetitions starting at an arbitrary offset of 17 bits.
   - Reaches LOCKED exactly one pattern after the first full window.
   - sync_o pulses every 256 valid bits; err_cnt_o = 0.
3. Error injection while LOCKED: flip bits 5 and 200 of one period → period_err_o = 2, err_cnt_o += 2, still LOCKED.
4. Loss of lock: inject 17 errors per period for 3 periods → SEARCH after the third wrap, locked_o = 0, counters frozen.
5. Inverted stream: feed ~pattern.
   - Feature defined → LOCKED with inverted_o = 1 and 0 errors.
   - Not defined → remains in SEARCH.
6. Gaps and clear: toggle data_val_i randomly at 30 % duty and pulse clear_i concurrently with a valid error bit → pointer alignment is kept, err_cnt_o = 0 after the clear.

Source files
------------

// File: rtl/msk_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msk_chk_pkg                                                  |
// | Description : Shared types, default reference pattern and popcount helper  |
// |               for the MSK pattern checker.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package msk_chk_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    // Widest vector the popcount helper accepts; narrower callers zero-extend.
    localparam int POPCNT_MAX_W = 256;

    localparam logic [255:0] FIXED_DATA_DEFAULT =
        256'h90103c5a_e7b2419d_6f08c3a1_5d2e94b7_0c61f8d3_a24e7b19_c85f30e6_ffa50ffe;

    function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            cnt = cnt + 32'(v[i]);
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msk_hamming_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msk_hamming_match                                            |
// | Description : Combinational Hamming-distance comparator of a received      |
// |               window against a reference word, with tolerance threshold.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msk_hamming_match
    import msk_chk_pkg::*;
#(
    parameter int SYNC_W   = 32,
    parameter int SYNC_TOL = 0
) (
    input  logic [SYNC_W-1:0]            i_window,
    input  logic [SYNC_W-1:0]            i_pattern,
    output logic                         o_match,
    output logic [$clog2(SYNC_W+1)-1:0]  o_dist
);

    localparam int c_dist_w = $clog2(SYNC_W+1);

    logic [POPCNT_MAX_W-1:0] w_diff_ext;
    int unsigned             w_cnt;

    always_comb begin
        w_diff_ext               = '0;
        w_diff_ext[SYNC_W-1:0]   = i_window ^ i_pattern;
        w_cnt                    = popcount(w_diff_ext);
    end

    assign o_match = (w_cnt <= $unsigned(SYNC_TOL));
    assign o_dist  = c_dist_w'(w_cnt);

endmodule
`default_nettype wire

// File: rtl/msk_pattern_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msk_pattern_checker                                          |
// | Description : Locks onto a repeating FDW-bit reference pattern in the      |
// |               decoded MSK stream and counts bit errors against it.         |
// |               Optional MSK_PATTERN_CHECKER_POLARITY_AUTO_EN adds inverted  |
// |               (180 degree) window matching.                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msk_pattern_checker
    import msk_chk_pkg::*;
#(
    parameter int              FDW            = 256,
    parameter logic [FDW-1:0]  FIXED_DATA     = FIXED_DATA_DEFAULT,
    parameter int              SYNC_W         = 32,
    parameter int              SYNC_TOL       = 0,
    parameter int              VERIFY_MAX_ERR = 2,
    parameter int              UNLOCK_ERR     = 16,
    parameter int              LOSS_CNT       = 3,
    parameter int              CNT_W          = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_i,
    input  logic                         data_val_i,
    input  logic                         clear_i,
    output logic [1:0]                   state_o,
    output logic                         locked_o,
    output logic                         sync_o,
    output logic [CNT_W-1:0]             bit_cnt_o,
    output logic [CNT_W-1:0]             err_cnt_o,
    output logic [$clog2(FDW+1)-1:0]     period_err_o,
    output logic                         inverted_o
);

    localparam int c_ptr_w  = $clog2(FDW);
    localparam int c_per_w  = $clog2(FDW+1);
    localparam int c_dist_w = $clog2(SYNC_W+1);
    localparam int c_loss_w = $clog2(LOSS_CNT+1);

    localparam logic [SYNC_W-1:0]   c_sync_win   = FIXED_DATA[FDW-1 -: SYNC_W];
    localparam logic [c_ptr_w-1:0]  c_ptr_start  = c_ptr_w'(SYNC_W % FDW);
    localparam logic [c_ptr_w-1:0]  c_ptr_last   = c_ptr_w'(FDW-1);
    localparam logic [c_per_w-1:0]  c_verify_max = c_per_w'(VERIFY_MAX_ERR);
    localparam logic [c_per_w-1:0]  c_unlock     = c_per_w'(UNLOCK_ERR);
    localparam logic [c_loss_w-1:0] c_loss_lim   = c_loss_w'(LOSS_CNT);
    localparam logic [CNT_W-1:0]    c_cnt_one    = CNT_W'(1);

    chk_state_t           r_state;
    // Only SYNC_W-1 history bits are stored; the newest bit is data_i itself.
    logic [SYNC_W-2:0]    r_shreg;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_per_w-1:0]   r_per;
    logic [c_loss_w-1:0]  r_loss;
    logic                 r_sync;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     r_err_cnt;
    logic [c_per_w-1:0]   r_period_err;

    logic [SYNC_W-1:0]    w_window;
    logic                 w_bit;
    logic [c_ptr_w-1:0]   w_idx;
    logic                 w_err;
    logic [c_per_w-1:0]   w_per_next;
    logic                 w_wrap;
    logic [c_ptr_w-1:0]   w_ptr_next;
    logic                 w_bad;
    logic [c_loss_w-1:0]  w_loss_inc;
    logic                 w_match_n;
    logic [c_dist_w-1:0]  w_dist_n;

    assign w_window = {r_shreg, data_i};

    msk_hamming_match #(
        .SYNC_W   (SYNC_W),
        .SYNC_TOL (SYNC_TOL)
    ) u_match_norm (
        .i_window  (w_window),
        .i_pattern (c_sync_win),
        .o_match   (w_match_n),
        .o_dist    (w_dist_n)
    );

`ifdef MSK_PATTERN_CHECKER_POLARITY_AUTO_EN
    logic                 r_inverted;
    logic                 w_match_i;
    logic [c_dist_w-1:0]  w_dist_i;

    msk_hamming_match #(
        .SYNC_W   (SYNC_W),
        .SYNC_TOL (SYNC_TOL)
    ) u_match_inv (
        .i_window  (w_window),
        .i_pattern (~c_sync_win),
        .o_match   (w_match_i),
        .o_dist    (w_dist_i)
    );

    assign w_bit      = data_i ^ r_inverted;
    assign inverted_o = r_inverted;
`else
    assign w_bit      = data_i;
    assign inverted_o = 1'b0;
`endif

    assign w_idx      = c_ptr_last - r_ptr;
    assign w_err      = (w_bit != FIXED_DATA[w_idx]);
    assign w_per_next = r_per + c_per_w'(w_err);
    assign w_wrap     = (r_ptr == c_ptr_last);
    assign w_ptr_next = w_wrap ? '0 : r_ptr + c_ptr_w'(1);
    assign w_bad      = (w_per_next > c_unlock);
    assign w_loss_inc = r_loss + c_loss_w'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_SEARCH;
            r_shreg      <= '0;
            r_ptr        <= '0;
            r_per        <= '0;
            r_loss       <= '0;
            r_sync       <= 1'b0;
            r_bit_cnt    <= '0;
            r_err_cnt    <= '0;
            r_period_err <= '0;
`ifdef MSK_PATTERN_CHECKER_POLARITY_AUTO_EN
            r_inverted   <= 1'b0;
`endif
        end else begin
            r_sync <= 1'b0;
            if (data_val_i) begin
                case (r_state)
                    ST_SEARCH: begin
                        r_shreg <= w_window[SYNC_W-2:0];
                        if (w_match_n) begin
                            r_state <= ST_VERIFY;
                            r_ptr   <= c_ptr_start;
                            r_per   <= c_per_w'(w_dist_n);
`ifdef MSK_PATTERN_CHECKER_POLARITY_AUTO_EN
                        end else if (w_match_i) begin
                            r_state    <= ST_VERIFY;
                            r_ptr      <= c_ptr_start;
                            r_per      <= c_per_w'(w_dist_i);
                            r_inverted <= 1'b1;
`endif
                        end
                    end
                    ST_VERIFY: begin
                        // Abort as soon as the period can no longer qualify.
                        if (w_per_next > c_verify_max) begin
                            r_state <= ST_SEARCH;
                            r_shreg <= '0;
                            r_ptr   <= '0;
                            r_per   <= '0;
                            r_loss  <= '0;
`ifdef MSK_PATTERN_CHECKER_POLARITY_AUTO_EN
                            r_inverted <= 1'b0;
`endif
                        end else if (w_wrap) begin
                            r_state <= ST_LOCKED;
                            r_ptr   <= '0;
                            r_per   <= '0;
                            r_loss  <= '0;
                        end else begin
                            r_ptr   <= w_ptr_next;
                            r_per   <= w_per_next;
                        end
                    end
                    ST_LOCKED: begin
                        r_ptr <= w_ptr_next;
                        if (r_bit_cnt != '1) begin
                            r_bit_cnt <= r_bit_cnt + c_cnt_one;
                        end
                        if (w_err && (r_err_cnt != '1)) begin
                            r_err_cnt <= r_err_cnt + c_cnt_one;
                        end
                        if (w_wrap) begin
                            r_per        <= '0;
                            r_period_err <= w_per_next;
                            // Loss on a wrap suppresses that wrap's sync pulse.
                            if (w_bad && (w_loss_inc >= c_loss_lim)) begin
                                r_state <= ST_SEARCH;
                                r_shreg <= '0;
                                r_loss  <= '0;
`ifdef MSK_PATTERN_CHECKER_POLARITY_AUTO_EN
                                r_inverted <= 1'b0;
`endif
                            end else begin
                                r_loss <= w_bad ? w_loss_inc : '0;
                                r_sync <= 1'b1;
                            end
                        end else begin
                            r_per <= w_per_next;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                        r_shreg <= '0;
                        r_ptr   <= '0;
                        r_per   <= '0;
                        r_loss  <= '0;
                    end
                endcase
            end
            if (clear_i) begin
                r_bit_cnt    <= '0;
                r_err_cnt    <= '0;
                r_period_err <= '0;
            end
        end
    end

    assign state_o      = r_state;
    assign locked_o     = (r_state == ST_LOCKED);
    assign sync_o       = r_sync;
    assign bit_cnt_o    = r_bit_cnt;
    assign err_cnt_o    = r_err_cnt;
    assign period_err_o = r_period_err;

endmodule
`default_nettype wire

// File: tb/tb_msk_pattern_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msk_pattern_checker                                       |
// | Description : Self-checking bench for msk_pattern_checker (period table    |
// |               with scoreboard plus hand-written lock/loss/gap sequences).  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msk_pattern_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_i;
    logic        data_val_i;
    logic        clear_i;
    logic [1:0]  state_o;
    logic        locked_o;
    logic        sync_o;
    logic [31:0] bit_cnt_o;
    logic [31:0] err_cnt_o;
    logic [8:0]  period_err_o;
    logic        inverted_o;

    always #5 clk = ~clk;

    msk_pattern_checker u_dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .data_val_i   (data_val_i),
        .clear_i      (clear_i),
        .state_o      (state_o),
        .locked_o     (locked_o),
        .sync_o       (sync_o),
        .bit_cnt_o    (bit_cnt_o),
        .err_cnt_o    (err_cnt_o),
        .period_err_o (period_err_o),
        .inverted_o   (inverted_o)
    );

    typedef struct {
        logic [1:0]  state;
        logic        sync;
        logic [8:0]  period_err;
        logic [31:0] err_cnt;
        logic [31:0] bit_cnt;
    } exp_t;

    typedef struct {
        int          nerr;
        int          start;
        int          stride;
        logic [8:0]  exp_per;
        logic [1:0]  exp_state;
        int          exp_syncs;
    } per_t;

    exp_t        sbq[$];
    per_t        tbl[7];
    logic [255:0] pat;
    int          n_checks = 0;
    int          n_errors = 0;
    int          sync_seen;
    int          v_at;
    int          l_at;
    int          nonsearch;
    int          exp_err;
    int          exp_bits;
    logic        b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Drive one cycle at the falling edge, then sample at the next falling edge.
    task automatic step(input logic d, input logic v, input logic c);
        exp_t e;
        data_i     = d;
        data_val_i = v;
        clear_i    = c;
        @(negedge clk);
        if (sync_o === 1'b1) sync_seen++;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_state",      64'(state_o),      64'(e.state));
            chk("sb_locked",     64'(locked_o),     64'(e.state == 2'd2));
            chk("sb_sync",       64'(sync_o),       64'(e.sync));
            chk("sb_period_err", 64'(period_err_o), 64'(e.period_err));
            chk("sb_err_cnt",    64'(err_cnt_o),    64'(e.err_cnt));
            chk("sb_bit_cnt",    64'(bit_cnt_o),    64'(e.bit_cnt));
        end
        data_val_i = 1'b0;
        clear_i    = 1'b0;
    endtask

    task automatic gap_bit(input logic d, input logic c);
        for (int g = 0; g < 40 && $urandom_range(0, 99) >= 30; g++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        step(d, 1'b1, c);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit is_err(input int i, input per_t r);
        return (r.nerr > 0) && (i >= r.start) && (((i - r.start) % r.stride) == 0)
               && (((i - r.start) / r.stride) < r.nerr);
    endfunction

    initial begin
        pat = 256'h90103c5a_e7b2419d_6f08c3a1_5d2e94b7_0c61f8d3_a24e7b19_c85f30e6_ffa50ffe;
        // nerr, start, stride, period_err, state after wrap, sync pulses
        tbl[0] = '{0,  0, 1,   9'd0,  2'd2, 1};
        tbl[1] = '{2,  5, 195, 9'd2,  2'd2, 1};
        tbl[2] = '{17, 3, 15,  9'd17, 2'd2, 1};
        tbl[3] = '{16, 3, 15,  9'd16, 2'd2, 1};
        tbl[4] = '{17, 3, 15,  9'd17, 2'd2, 1};
        tbl[5] = '{17, 3, 15,  9'd17, 2'd2, 1};
        tbl[6] = '{17, 3, 15,  9'd17, 2'd0, 0};

        rst = 1'b1; data_i = 1'b0; data_val_i = 1'b0; clear_i = 1'b0;
        sync_seen = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state",      64'(state_o),      0);
        chk("rst_locked",     64'(locked_o),     0);
        chk("rst_sync",       64'(sync_o),       0);
        chk("rst_bit_cnt",    64'(bit_cnt_o),    0);
        chk("rst_err_cnt",    64'(err_cnt_o),    0);
        chk("rst_period_err", 64'(period_err_o), 0);
        chk("rst_inverted",   64'(inverted_o),   0);
        rst = 1'b0;

        // Clean stream entering at pattern offset 17.
        v_at = -1; l_at = -1;
        for (int k = 0; k < 495; k++) begin
            step(pat[255 - ((17 + k) % 256)], 1'b1, 1'b0);
            if (state_o == 2'd1 && v_at < 0) v_at = k + 1;
            if (state_o == 2'd2 && l_at < 0) l_at = k + 1;
        end
        chk("verify_at_bit", 64'(v_at), 271);
        chk("lock_at_bit",   64'(l_at), 495);
        chk("lock_err_cnt",  64'(err_cnt_o), 0);
        chk("lock_inverted", 64'(inverted_o), 0);

        // Period table: one LOCKED period per entry, wrap bit checked via scoreboard.
        exp_err = 0; exp_bits = 0;
        for (int k = 0; k < 7; k++) begin
            sync_seen = 0;
            for (int i = 0; i < 256; i++) begin
                b = pat[255 - i] ^ is_err(i, tbl[k]);
                exp_bits++;
                if (is_err(i, tbl[k])) exp_err++;
                if (i == 255) begin
                    sbq.push_back('{tbl[k].exp_state, tbl[k].exp_syncs != 0, tbl[k].exp_per,
                                    32'(exp_err), 32'(exp_bits)});
                end
                step(b, 1'b1, 1'b0);
            end
            chk("period_sync_count", 64'(sync_seen), 64'(tbl[k].exp_syncs));
        end
        chk("sb_drained", 64'(sbq.size()), 0);

        // After loss the counters stay frozen while the checker re-acquires.
        sync_seen = 0;
        for (int i = 0; i < 100; i++) step(pat[255 - i], 1'b1, 1'b0);
        chk("reacq_state",   64'(state_o),   1);
        chk("frozen_bits",   64'(bit_cnt_o), 1792);
        chk("frozen_errs",   64'(err_cnt_o), 86);
        chk("frozen_locked", 64'(locked_o),  0);
        chk("frozen_sync",   64'(sync_seen), 0);
        for (int i = 100; i < 256; i++) step(pat[255 - i], 1'b1, 1'b0);
        chk("relock_state", 64'(state_o), 2);
        for (int i = 0; i < 40; i++) step(pat[255 - i], 1'b1, 1'b0);
        chk("relock_bits", 64'(bit_cnt_o), 1832);

        // Reset while LOCKED.
        rst = 1'b1; data_i = pat[215]; data_val_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; data_val_i = 1'b0;
        chk("midrst_state",   64'(state_o),      0);
        chk("midrst_bits",    64'(bit_cnt_o),    0);
        chk("midrst_errs",    64'(err_cnt_o),    0);
        chk("midrst_per_err", 64'(period_err_o), 0);

        // VERIFY early abort on the third error.
        for (int i = 0; i < 43; i++) begin
            step(pat[255 - i] ^ (i >= 40), 1'b1, 1'b0);
            if (i == 41) chk("verify_two_errs_state", 64'(state_o), 1);
        end
        chk("verify_abort_state", 64'(state_o), 0);

        // Exactly VERIFY_MAX_ERR errors still promotes to LOCKED.
        do_reset();
        for (int i = 0; i < 256; i++) step(pat[255 - i] ^ (i == 40 || i == 41), 1'b1, 1'b0);
        chk("verify_max_lock", 64'(state_o), 2);

        // Gapped stream with clear coinciding with an error bit.
        do_reset();
        for (int i = 0; i < 256; i++) gap_bit(pat[255 - i], 1'b0);
        chk("gap_lock_state", 64'(state_o), 2);
        sync_seen = 0;
        for (int i = 0; i < 256; i++) begin
            gap_bit(pat[255 - i] ^ (i == 100 || i == 150), i == 100);
            if (i == 100) begin
                chk("clear_err_cnt", 64'(err_cnt_o), 0);
                chk("clear_bit_cnt", 64'(bit_cnt_o), 0);
            end
            if (i == 254) chk("gap_no_early_sync", 64'(sync_seen), 0);
            if (i == 255) chk("gap_sync_at_wrap", 64'(sync_o), 1);
        end
        chk("gap_err_cnt", 64'(err_cnt_o), 1);
        chk("gap_bit_cnt", 64'(bit_cnt_o), 155);
        chk("gap_state",   64'(state_o),   2);

        // Inverted stream.
        do_reset();
        nonsearch = 0; l_at = -1; sync_seen = 0;
        for (int k = 0; k < 512; k++) begin
            step(~pat[255 - (k % 256)], 1'b1, 1'b0);
            if (state_o != 2'd0) nonsearch++;
            if (state_o == 2'd2 && l_at < 0) l_at = k + 1;
        end
`ifdef MSK_PATTERN_CHECKER_POLARITY_AUTO_EN
        chk("inv_lock_at",  64'(l_at),         256);
        chk("inv_flag",     64'(inverted_o),   1);
        chk("inv_err_cnt",  64'(err_cnt_o),    0);
        chk("inv_bit_cnt",  64'(bit_cnt_o),    256);
        chk("inv_per_err",  64'(period_err_o), 0);
        chk("inv_syncs",    64'(sync_seen),    1);
`else
        chk("inv_nonsearch", 64'(nonsearch),  0);
        chk("inv_flag",      64'(inverted_o), 0);
        chk("inv_bit_cnt",   64'(bit_cnt_o),  0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
